store_buffer_drain: RTL and testbench

- Consumer end of the data-cache store buffer.
- Pops the oldest committed store, issues it as a write request to the dcache write port, and waits for the hit/miss response.
- On a miss it retries after the line fill completes.
- Arbitrates against pending loads with a starvation limit, and supports a flush that drains the buffer completely.

---
 rtl/store_buffer_drain_if.sv | 39 +++
 rtl/store_buffer_drain.sv | 169 ++++++++++++++++
 tb/tb_store_buffer_drain.sv | 352 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/store_buffer_drain_if.sv
// store_buffer_drain_if
//   Groups the signals between the store-buffer drain engine and the data cache
//   write port. Each store crosses it in three steps: a request handshake, a
//   hit/miss response, and on a miss a fill-complete pulse.
//
//   Signals:
//     wr_valid   drain -> dcache  write request valid
//     wr_addr    drain -> dcache  request address
//     wr_data    drain -> dcache  request data
//     wr_size    drain -> dcache  request size (0=byte, 1=half, 2=word)
//     wr_ready   dcache -> drain  request accepted this cycle
//     rsp_valid  dcache -> drain  response valid
//     rsp_hit    dcache -> drain  1=hit/written, 0=miss
//     fill_done  dcache -> drain  pulse: the missed line is now resident
//
//   Modports: master = drain engine, slave = dcache.
interface store_buffer_drain_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                  wr_valid;
  logic [ADDR_WIDTH-1:0] wr_addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic [1:0]            wr_size;
  logic                  wr_ready;
  logic                  rsp_valid;
  logic                  rsp_hit;
  logic                  fill_done;

  modport master (
    output wr_valid, wr_addr, wr_data, wr_size,
    input  wr_ready, rsp_valid, rsp_hit, fill_done
  );

  modport slave (
    input  wr_valid, wr_addr, wr_data, wr_size,
    output wr_ready, rsp_valid, rsp_hit, fill_done
  );
endinterface

// File: rtl/store_buffer_drain.sv
// store_buffer_drain
//   Consumer end of the data-cache store buffer. Pops the oldest committed
//   store, issues it on the dcache write port and waits for the response.
//   A miss parks the store until the line fill completes and then re-issues
//   the same held store. Stores yield to pending loads, but only for
//   STALL_LIMIT consecutive cycles. A flush drains the buffer completely while
//   ignoring loads, then pulses flush_done.
//
//   Ports:
//     clock          system clock
//     reset          synchronous, active-low reset
//     sb_empty       store buffer holds no valid entry
//     sb_addr/data/size  oldest entry (valid when !sb_empty)
//     sb_pop         one-cycle pulse removing the oldest entry
//     ld_pending     a load wants the dcache port this cycle
//     wr             dcache write port (store_buffer_drain_if.master)
//     flush_req      pulse: drain the buffer fully
//     flush_done     one-cycle pulse: flush complete
//     busy           engine not idle
//     drained_count  completed stores, wraps at 2^16
//
//   STALL_LIMIT must lie in 1..15.
module store_buffer_drain #(
  parameter int ADDR_WIDTH  = 32,
  parameter int DATA_WIDTH  = 32,
  parameter int STALL_LIMIT = 8
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  sb_empty,
  input  logic [ADDR_WIDTH-1:0] sb_addr,
  input  logic [DATA_WIDTH-1:0] sb_data,
  input  logic [1:0]            sb_size,
  output logic                  sb_pop,
  input  logic                  ld_pending,
  store_buffer_drain_if.master  wr,
  input  logic                  flush_req,
  output logic                  flush_done,
  output logic                  busy,
  output logic [15:0]           drained_count
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    ISSUE     = 2'd1,
    WAIT_RSP  = 2'd2,
    MISS_WAIT = 2'd3
  } state_t;

  localparam logic [3:0] STALL_MAX = 4'(STALL_LIMIT);

  state_t                state_reg, state_next;
  logic [3:0]            stall_cnt_reg, stall_cnt_next;
  logic                  flush_active_reg, flush_active_next;
  logic [ADDR_WIDTH-1:0] addr_reg;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [1:0]            size_reg;
  logic [15:0]           drained_reg;

  logic pop;
  logic hit_done;
  logic flush_complete;

  // Next-state and handshake decode.
  always_comb begin
    state_next = state_reg;
    pop        = 1'b0;
    hit_done   = 1'b0;

    case (state_reg)
      IDLE: begin
        // Loads normally win the port; a flush or an exhausted stall budget
        // overrides them.
        if (!sb_empty &&
            (!ld_pending || flush_active_reg || (stall_cnt_reg == STALL_MAX))) begin
          pop        = 1'b1;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        if (wr.wr_ready) begin
          state_next = WAIT_RSP;
        end
      end
      WAIT_RSP: begin
        // Only looked at after acceptance, so a response coinciding with the
        // accepting cycle is never consumed.
        if (wr.rsp_valid) begin
          if (wr.rsp_hit) begin
            hit_done   = 1'b1;
            state_next = IDLE;
          end else begin
            state_next = MISS_WAIT;
          end
        end
      end
      MISS_WAIT: begin
        if (wr.fill_done) begin
          state_next = ISSUE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Stall budget: counts IDLE cycles lost to loads while a store waits.
  always_comb begin
    stall_cnt_next = stall_cnt_reg;
    if (sb_empty) begin
      stall_cnt_next = 4'd0;
    end else if (state_reg == IDLE) begin
      if (pop) begin
        stall_cnt_next = 4'd0;
      end else if (ld_pending && (stall_cnt_reg != STALL_MAX)) begin
        stall_cnt_next = stall_cnt_reg + 4'd1;
      end
    end
  end

  // Flush bookkeeping. Completion wins over a coincident flush_req, which is
  // a no-op while a flush is already active.
  assign flush_complete = flush_active_reg && (state_reg == IDLE) && sb_empty;

  always_comb begin
    flush_active_next = flush_active_reg;
    if (flush_complete) begin
      flush_active_next = 1'b0;
    end else if (flush_req) begin
      flush_active_next = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_reg        <= IDLE;
      stall_cnt_reg    <= 4'd0;
      flush_active_reg <= 1'b0;
      addr_reg         <= '0;
      data_reg         <= '0;
      size_reg         <= 2'd0;
      drained_reg      <= 16'd0;
    end else begin
      state_reg        <= state_next;
      stall_cnt_reg    <= stall_cnt_next;
      flush_active_reg <= flush_active_next;
      // Captured only on the pop so a retry after a miss reuses the same store.
      if (pop) begin
        addr_reg <= sb_addr;
        data_reg <= sb_data;
        size_reg <= sb_size;
      end
      if (hit_done) begin
        drained_reg <= drained_reg + 16'd1;
      end
    end
  end

  // Pulses are qualified by reset so nothing leaks out while it is held.
  assign sb_pop        = pop && reset;
  assign flush_done    = flush_complete && reset;
  assign busy          = (state_reg != IDLE);
  assign drained_count = drained_reg;

  assign wr.wr_valid = (state_reg == ISSUE);
  assign wr.wr_addr  = addr_reg;
  assign wr.wr_data  = data_reg;
  assign wr.wr_size  = size_reg;

endmodule

// File: tb/tb_store_buffer_drain.sv
// tb_store_buffer_drain
//   Directed bench for store_buffer_drain. A small array models the store
//   buffer and advances whenever sb_pop is seen at a clock edge; the dcache
//   side is driven directly. Expected values are hand-computed constants.
module tb_store_buffer_drain;

  logic        clock = 1'b0;
  logic        reset;
  logic        sb_empty;
  logic [31:0] sb_addr;
  logic [31:0] sb_data;
  logic [1:0]  sb_size;
  logic        sb_pop;
  logic        ld_pending;
  logic        flush_req;
  logic        flush_done;
  logic        busy;
  logic [15:0] drained_count;

  store_buffer_drain_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) wr_if ();

  store_buffer_drain #(
    .ADDR_WIDTH (32),
    .DATA_WIDTH (32),
    .STALL_LIMIT(8)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .sb_empty     (sb_empty),
    .sb_addr      (sb_addr),
    .sb_data      (sb_data),
    .sb_size      (sb_size),
    .sb_pop       (sb_pop),
    .ld_pending   (ld_pending),
    .wr           (wr_if.master),
    .flush_req    (flush_req),
    .flush_done   (flush_done),
    .busy         (busy),
    .drained_count(drained_count)
  );

  always #5 clock = ~clock;

  int errors = 0;
  int checks = 0;

  logic [31:0] ent_addr [0:15];
  logic [31:0] ent_data [0:15];
  logic [1:0]  ent_size [0:15];
  int head;
  int tail;
  int pops;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      $error("%s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic present();
    sb_empty = (head == tail);
    sb_addr  = ent_addr[head];
    sb_data  = ent_data[head];
    sb_size  = ent_size[head];
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] d, input logic [1:0] s);
    ent_addr[tail] = a;
    ent_data[tail] = d;
    ent_size[tail] = s;
    tail++;
    present();
  endtask

  // Advance one clock; the modelled buffer drops its head if sb_pop was high.
  task automatic tick();
    logic p;
    #1;
    p = sb_pop;
    @(posedge clock);
    #1;
    if (p) begin
      head++;
      pops++;
    end
    present();
  endtask

  task automatic rsp(input logic v, input logic h);
    wr_if.rsp_valid = v;
    wr_if.rsp_hit   = h;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset      = 1'b0;
    ld_pending = 1'b0;
    flush_req  = 1'b0;
    wr_if.wr_ready  = 1'b0;
    wr_if.fill_done = 1'b0;
    rsp(1'b0, 1'b0);
    for (int i = 0; i < 16; i++) begin
      ent_addr[i] = '0;
      ent_data[i] = '0;
      ent_size[i] = '0;
    end
    head = 0;
    tail = 0;
    pops = 0;
    present();
    tick();
    tick();

    // Reset state
    #1;
    chk("rst_busy",     64'(busy),           64'd0);
    chk("rst_wr_valid", 64'(wr_if.wr_valid), 64'd0);
    chk("rst_sb_pop",   64'(sb_pop),         64'd0);
    chk("rst_flush",    64'(flush_done),     64'd0);
    chk("rst_drained",  64'(drained_count),  64'd0);
    chk("rst_wr_addr",  64'(wr_if.wr_addr),  64'd0);
    reset = 1'b1;
    tick();

    // Single store, hit
    wr_if.wr_ready = 1'b1;
    push(32'h100, 32'hDEADBEEF, 2'd2);
    #1;
    chk("t1_pop_c0",  64'(sb_pop), 64'd1);
    chk("t1_busy_c0", 64'(busy),   64'd0);
    tick();
    #1;
    chk("t1_valid_c1", 64'(wr_if.wr_valid), 64'd1);
    chk("t1_addr_c1",  64'(wr_if.wr_addr),  64'h100);
    chk("t1_data_c1",  64'(wr_if.wr_data),  64'hDEADBEEF);
    chk("t1_size_c1",  64'(wr_if.wr_size),  64'd2);
    chk("t1_nopop_c1", 64'(sb_pop),         64'd0);
    tick();
    rsp(1'b1, 1'b1);
    #1;
    chk("t1_busy_c2",  64'(busy),           64'd1);
    chk("t1_valid_c2", 64'(wr_if.wr_valid), 64'd0);
    tick();
    rsp(1'b0, 1'b0);
    #1;
    chk("t1_idle_c3",    64'(busy),          64'd0);
    chk("t1_drained_c3", 64'(drained_count), 64'd1);
    chk("t1_pops",       64'(pops),          64'd1);

    // Backpressure: five cycles of wr_ready low
    wr_if.wr_ready = 1'b0;
    push(32'h204, 32'h12345678, 2'd1);
    #1;
    chk("t2_pop", 64'(sb_pop), 64'd1);
    tick();
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("t2_hold_valid", 64'(wr_if.wr_valid), 64'd1);
      chk("t2_hold_addr",  64'(wr_if.wr_addr),  64'h204);
      chk("t2_hold_data",  64'(wr_if.wr_data),  64'h12345678);
      chk("t2_hold_size",  64'(wr_if.wr_size),  64'd1);
      tick();
    end
    // Acceptance with a coincident response that must be ignored
    wr_if.wr_ready = 1'b1;
    rsp(1'b1, 1'b1);
    #1;
    chk("t2_acc_valid", 64'(wr_if.wr_valid), 64'd1);
    chk("t2_acc_addr",  64'(wr_if.wr_addr),  64'h204);
    tick();
    rsp(1'b0, 1'b0);
    #1;
    chk("t2_wait_busy",    64'(busy),           64'd1);
    chk("t2_wait_valid",   64'(wr_if.wr_valid), 64'd0);
    chk("t2_early_rsp_ign", 64'(drained_count), 64'd1);
    rsp(1'b1, 1'b1);
    tick();
    rsp(1'b0, 1'b0);
    #1;
    chk("t2_idle",    64'(busy),          64'd0);
    chk("t2_drained", 64'(drained_count), 64'd2);
    chk("t2_pops",    64'(pops),          64'd2);

    // Miss, fill after 10 cycles, retry with same data
    push(32'h308, 32'hCAFEF00D, 2'd0);
    #1;
    chk("t3_pop", 64'(sb_pop), 64'd1);
    tick();
    #1;
    chk("t3_valid", 64'(wr_if.wr_valid), 64'd1);
    tick();
    rsp(1'b1, 1'b0);
    tick();
    rsp(1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      #1;
      chk("t3_miss_valid", 64'(wr_if.wr_valid), 64'd0);
      chk("t3_miss_busy",  64'(busy),           64'd1);
      tick();
    end
    wr_if.fill_done = 1'b1;
    tick();
    wr_if.fill_done = 1'b0;
    #1;
    chk("t3_retry_valid", 64'(wr_if.wr_valid), 64'd1);
    chk("t3_retry_addr",  64'(wr_if.wr_addr),  64'h308);
    chk("t3_retry_data",  64'(wr_if.wr_data),  64'hCAFEF00D);
    chk("t3_retry_size",  64'(wr_if.wr_size),  64'd0);
    chk("t3_no_repop",    64'(pops),           64'd3);
    tick();
    rsp(1'b1, 1'b1);
    tick();
    rsp(1'b0, 1'b0);
    #1;
    chk("t3_drained", 64'(drained_count), 64'd3);
    chk("t3_idle",    64'(busy),          64'd0);
    // fill_done in IDLE is ignored
    wr_if.fill_done = 1'b1;
    tick();
    wr_if.fill_done = 1'b0;
    #1;
    chk("t3_stray_fill", 64'(busy), 64'd0);

    // Starvation: loads held, pop forced after 8 stall cycles
    ld_pending = 1'b1;
    push(32'h400, 32'h11111111, 2'd2);
    push(32'h404, 32'h22222222, 2'd2);
    push(32'h408, 32'h33333333, 2'd2);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t4_stall_a", 64'(sb_pop), 64'd0);
      tick();
    end
    #1;
    chk("t4_force_pop_a", 64'(sb_pop), 64'd1);
    tick();
    #1;
    chk("t4_addr_a", 64'(wr_if.wr_addr), 64'h400);
    tick();
    rsp(1'b1, 1'b1);
    tick();
    rsp(1'b0, 1'b0);
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("t4_stall_b", 64'(sb_pop), 64'd0);
      tick();
    end
    #1;
    chk("t4_force_pop_b", 64'(sb_pop), 64'd1);
    tick();
    #1;
    chk("t4_addr_b", 64'(wr_if.wr_addr), 64'h404);
    tick();
    rsp(1'b1, 1'b1);
    tick();
    rsp(1'b0, 1'b0);
    ld_pending = 1'b0;
    #1;
    chk("t4_pop_c", 64'(sb_pop), 64'd1);
    tick();
    #1;
    chk("t4_addr_c", 64'(wr_if.wr_addr), 64'h408);
    tick();
    rsp(1'b1, 1'b1);
    tick();
    rsp(1'b0, 1'b0);
    #1;
    chk("t4_drained", 64'(drained_count), 64'd6);

    // Flush: 4 entries drained despite loads
    ld_pending = 1'b1;
    for (int i = 0; i < 4; i++) begin
      push(32'h600 + 32'(i * 4), 32'hA0000000 + 32'(i), 2'd2);
    end
    flush_req = 1'b1;
    #1;
    chk("t5_no_pop_pre", 64'(sb_pop), 64'd0);
    tick();
    flush_req = 1'b0;
    for (int s = 0; s < 4; s++) begin
      #1;
      chk("t5_pop",       64'(sb_pop),     64'd1);
      chk("t5_no_done_a", 64'(flush_done), 64'd0);
      tick();
      #1;
      chk("t5_addr", 64'(wr_if.wr_addr), 64'h600 + 64'(s * 4));
      tick();
      rsp(1'b1, 1'b1);
      #1;
      chk("t5_no_done_b", 64'(flush_done), 64'd0);
      tick();
      rsp(1'b0, 1'b0);
    end
    #1;
    chk("t5_done",    64'(flush_done),    64'd1);
    chk("t5_drained", 64'(drained_count), 64'd10);
    tick();
    #1;
    chk("t5_done_pulse", 64'(flush_done), 64'd0);
    // Flush requested when already idle and empty: done on the next cycle
    flush_req = 1'b1;
    #1;
    chk("t5_quick_c0", 64'(flush_done), 64'd0);
    tick();
    flush_req = 1'b0;
    #1;
    chk("t5_quick_c1", 64'(flush_done), 64'd1);
    tick();
    #1;
    chk("t5_quick_c2", 64'(flush_done), 64'd0);

    // Reset during WAIT_RSP
    ld_pending = 1'b0;
    push(32'h500, 32'h55AA55AA, 2'd2);
    #1;
    chk("t6_pop", 64'(sb_pop), 64'd1);
    tick();
    tick();
    #1;
    chk("t6_busy_wait", 64'(busy), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    #1;
    chk("t6_busy",     64'(busy),           64'd0);
    chk("t6_valid",    64'(wr_if.wr_valid), 64'd0);
    chk("t6_addr",     64'(wr_if.wr_addr),  64'd0);
    chk("t6_data",     64'(wr_if.wr_data),  64'd0);
    chk("t6_size",     64'(wr_if.wr_size),  64'd0);
    chk("t6_drained",  64'(drained_count),  64'd0);
    chk("t6_sb_pop",   64'(sb_pop),         64'd0);
    chk("t6_flush",    64'(flush_done),     64'd0);
    rsp(1'b1, 1'b1);
    tick();
    rsp(1'b0, 1'b0);
    #1;
    chk("t6_late_rsp", 64'(drained_count), 64'd0);
    chk("t6_idle",     64'(busy),          64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
